// File: rtl/sr_jk_flop_bank_if.sv
// ---------------------------------------------------------------------------
// sr_jk_flop_bank_if
// Bundles the control inputs and status outputs of sr_jk_flop_bank.
//   en, mode, s, r, clr_err    : driven by the master (user logic / bench)
//   q, qb, conflict,
//   conflict_cnt, err_sticky   : driven by the slave (the flop bank)
// clk and reset are kept as plain ports on the bank itself.
// ---------------------------------------------------------------------------
interface sr_jk_flop_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             conflict;
  logic [CNT_W-1:0] conflict_cnt;
  logic             err_sticky;

  modport master (
    output en, mode, s, r, clr_err,
    input  q, qb, conflict, conflict_cnt, err_sticky
  );

  modport slave (
    input  en, mode, s, r, clr_err,
    output q, qb, conflict, conflict_cnt, err_sticky
  );
endinterface

// File: rtl/sr_jk_flop_bank.sv
// ---------------------------------------------------------------------------
// sr_jk_flop_bank
// Bank of WIDTH clocked bistable elements sharing one mode select
// (SR / JK / D / T). SR cycles where any bit sees s=r=1 are flagged as
// protocol errors: a one-cycle conflict pulse, a saturating event counter
// and a sticky error bit.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; loads RESET_VAL, clears error state
//   bus    : sr_jk_flop_bank_if.slave
//     en           update enable (low: q and counter hold)
//     mode         00 SR, 01 JK, 10 D, 11 T
//     s, r         set/J/D/T and reset/K per bit (r unused in D and T)
//     clr_err      clears conflict_cnt and err_sticky
//     q, qb        registered state and its combinational complement
//     conflict     pulse on the cycle after an SR conflict
//     conflict_cnt saturating count of SR conflict cycles
//     err_sticky   set by any SR conflict until reset or clr_err
// ---------------------------------------------------------------------------
module sr_jk_flop_bank #(
  parameter int               WIDTH       = 8,
  parameter int               SR_CONFLICT = 2,
  parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}},
  parameter int               CNT_W       = 8
) (
  input  logic                clk,
  input  logic                reset,
  sr_jk_flop_bank_if.slave    bus
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_p1;
  logic             conflict_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic             sticky_p1;

  logic [WIDTH-1:0] q_nxt;
  logic             conflict_evt;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + CNT_ONE;
  endfunction

  // Value taken by bits that see s=r=1 in SR mode.
  function automatic logic [WIDTH-1:0] sr_resolve(input logic [WIDTH-1:0] q);
    case (SR_CONFLICT)
      0:       return q;
      1:       return {WIDTH{1'b1}};
      default: return {WIDTH{1'b0}};
    endcase
  endfunction

  // Stage p0: next-state decode from current q and the sampled inputs.
  always_comb begin
    q_nxt = q_p1;
    case (bus.mode)
      MODE_SR: begin
        // (q | s) & ~r covers hold/set/reset; conflicting bits are
        // then overridden with the resolved value.
        q_nxt = (((q_p1 | bus.s) & ~bus.r) & ~(bus.s & bus.r))
              | (sr_resolve(q_p1) & (bus.s & bus.r));
      end
      MODE_JK: q_nxt = (bus.s & ~q_p1) | (~bus.r & q_p1);
      MODE_D:  q_nxt = bus.s;
      MODE_T:  q_nxt = q_p1 ^ bus.s;
      default: q_nxt = q_p1;
    endcase
  end

  assign conflict_evt = bus.en && (bus.mode == MODE_SR) && (|(bus.s & bus.r));

  // Stage p1: state and error bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_p1        <= RESET_VAL;
      conflict_p1 <= 1'b0;
      cnt_p1      <= '0;
      sticky_p1   <= 1'b0;
    end else begin
      if (bus.en) begin
        q_p1 <= q_nxt;
      end
      conflict_p1 <= conflict_evt;
      if (conflict_evt) begin
        // A clear landing with a new event restarts the count at one.
        cnt_p1    <= bus.clr_err ? CNT_ONE : sat_inc(cnt_p1);
        sticky_p1 <= 1'b1;
      end else if (bus.clr_err) begin
        cnt_p1    <= '0;
        sticky_p1 <= 1'b0;
      end
    end
  end

  assign bus.q            = q_p1;
  assign bus.qb           = ~q_p1;
  assign bus.conflict     = conflict_p1;
  assign bus.conflict_cnt = cnt_p1;
  assign bus.err_sticky   = sticky_p1;

endmodule

// File: tb/tb_sr_jk_flop_bank.sv
// ---------------------------------------------------------------------------
// tb_sr_jk_flop_bank
// Three banks (SR_CONFLICT = 2, 1, 0) with RESET_VAL = 8'hA5 and CNT_W = 2
// receive identical stimulus; each vector lists the expected q of every
// bank plus the expected error status, which is the same for all three.
// ---------------------------------------------------------------------------
module tb_sr_jk_flop_bank;

  logic clk;
  logic reset;

  sr_jk_flop_bank_if #(.WIDTH(8), .CNT_W(2)) if2 ();
  sr_jk_flop_bank_if #(.WIDTH(8), .CNT_W(2)) if1 ();
  sr_jk_flop_bank_if #(.WIDTH(8), .CNT_W(2)) if0 ();

  sr_jk_flop_bank #(.WIDTH(8), .SR_CONFLICT(2), .RESET_VAL(8'hA5), .CNT_W(2))
    dut2 (.clk(clk), .reset(reset), .bus(if2.slave));
  sr_jk_flop_bank #(.WIDTH(8), .SR_CONFLICT(1), .RESET_VAL(8'hA5), .CNT_W(2))
    dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  sr_jk_flop_bank #(.WIDTH(8), .SR_CONFLICT(0), .RESET_VAL(8'hA5), .CNT_W(2))
    dut0 (.clk(clk), .reset(reset), .bus(if0.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] s;
    logic [7:0] r;
    logic       clr;
    logic [7:0] q2;
    logic [7:0] q1;
    logic [7:0] q0;
    logic       cf;
    logic [1:0] cnt;
    logic       st;
  } vec_t;

  vec_t vt[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic rst, input logic en, input logic [1:0] mode,
                     input logic [7:0] s, input logic [7:0] r, input logic clr,
                     input logic [7:0] q2, input logic [7:0] q1, input logic [7:0] q0,
                     input logic cf, input logic [1:0] cnt, input logic st);
    vec_t v;
    v = '{rst, en, mode, s, r, clr, q2, q1, q0, cf, cnt, st};
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    reset       = v.rst;
    if2.en      = v.en;   if1.en      = v.en;   if0.en      = v.en;
    if2.mode    = v.mode; if1.mode    = v.mode; if0.mode    = v.mode;
    if2.s       = v.s;    if1.s       = v.s;    if0.s       = v.s;
    if2.r       = v.r;    if1.r       = v.r;    if0.r       = v.r;
    if2.clr_err = v.clr;  if1.clr_err = v.clr;  if0.clr_err = v.clr;
    @(posedge clk);
    #1;
    chk("q_rs2",   idx, if2.q,  v.q2);
    chk("qb_rs2",  idx, if2.qb, ~v.q2);
    chk("q_set1",  idx, if1.q,  v.q1);
    chk("q_hold0", idx, if0.q,  v.q0);
    chk("conflict",     idx, {7'b0, if2.conflict},   {7'b0, v.cf});
    chk("conflict_cnt", idx, {6'b0, if2.conflict_cnt}, {6'b0, v.cnt});
    chk("err_sticky",   idx, {7'b0, if2.err_sticky}, {7'b0, v.st});
    chk("cnt_set1",     idx, {6'b0, if1.conflict_cnt}, {6'b0, v.cnt});
    chk("cnt_hold0",    idx, {6'b0, if0.conflict_cnt}, {6'b0, v.cnt});
  endtask

  initial begin
    //   rst en mode   s      r      clr q2     q1     q0     cf cnt st
    add(1, 0, 2'b00, 8'h00, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 0, 0, 0);
    add(1, 1, 2'b00, 8'hFF, 8'hFF, 1, 8'hA5, 8'hA5, 8'hA5, 0, 0, 0);
    add(0, 1, 2'b00, 8'h00, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 0, 0, 0);
    add(0, 1, 2'b00, 8'h00, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 0, 0, 0);
    add(0, 1, 2'b00, 8'h00, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 0, 0, 0);
    add(0, 1, 2'b10, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    add(0, 1, 2'b00, 8'h0F, 8'h00, 0, 8'h0F, 8'h0F, 8'h0F, 0, 0, 0);
    add(0, 1, 2'b00, 8'h03, 8'h01, 0, 8'h0E, 8'h0F, 8'h0F, 1, 1, 1);
    add(0, 1, 2'b00, 8'h00, 8'h00, 0, 8'h0E, 8'h0F, 8'h0F, 0, 1, 1);
    add(0, 1, 2'b10, 8'h0F, 8'h00, 0, 8'h0F, 8'h0F, 8'h0F, 0, 1, 1);
    add(0, 1, 2'b01, 8'hFF, 8'hFF, 0, 8'hF0, 8'hF0, 8'hF0, 0, 1, 1);
    add(0, 1, 2'b01, 8'hFF, 8'hFF, 0, 8'h0F, 8'h0F, 8'h0F, 0, 1, 1);
    add(0, 1, 2'b11, 8'h81, 8'h00, 0, 8'h8E, 8'h8E, 8'h8E, 0, 1, 1);
    add(0, 1, 2'b10, 8'h3C, 8'hFF, 0, 8'h3C, 8'h3C, 8'h3C, 0, 1, 1);
    add(0, 0, 2'b10, 8'h00, 8'h00, 0, 8'h3C, 8'h3C, 8'h3C, 0, 1, 1);
    add(0, 0, 2'b00, 8'hFF, 8'hFF, 0, 8'h3C, 8'h3C, 8'h3C, 0, 1, 1);
    add(0, 0, 2'b00, 8'h00, 8'h00, 1, 8'h3C, 8'h3C, 8'h3C, 0, 0, 0);
    add(0, 1, 2'b00, 8'h01, 8'h01, 0, 8'h3C, 8'h3D, 8'h3C, 1, 1, 1);
    add(0, 1, 2'b00, 8'h01, 8'h01, 0, 8'h3C, 8'h3D, 8'h3C, 1, 2, 1);
    add(0, 1, 2'b00, 8'h01, 8'h01, 0, 8'h3C, 8'h3D, 8'h3C, 1, 3, 1);
    add(0, 1, 2'b00, 8'h01, 8'h01, 0, 8'h3C, 8'h3D, 8'h3C, 1, 3, 1);
    add(0, 1, 2'b00, 8'h01, 8'h01, 0, 8'h3C, 8'h3D, 8'h3C, 1, 3, 1);
    add(0, 1, 2'b00, 8'h00, 8'h00, 1, 8'h3C, 8'h3D, 8'h3C, 0, 0, 0);
    add(0, 1, 2'b00, 8'h01, 8'h01, 1, 8'h3C, 8'h3D, 8'h3C, 1, 1, 1);
    add(0, 1, 2'b00, 8'h00, 8'h00, 0, 8'h3C, 8'h3D, 8'h3C, 0, 1, 1);
    add(0, 1, 2'b01, 8'hFF, 8'hFF, 0, 8'hC3, 8'hC2, 8'hC3, 0, 1, 1);
    add(0, 1, 2'b00, 8'h01, 8'h01, 0, 8'hC2, 8'hC3, 8'hC3, 1, 2, 1);
    add(1, 1, 2'b00, 8'h01, 8'h01, 1, 8'hA5, 8'hA5, 8'hA5, 0, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i], i);
    end

    // Conflict immediately followed by en=0 with s=r still high: the pulse
    // must drop and the count freeze, then clr_err with en=0 still clears.
    apply('{1'b0, 1'b1, 2'b00, 8'h01, 8'h01, 1'b0,
            8'hA4, 8'hA5, 8'hA5, 1'b1, 2'd1, 1'b1}, 100);
    apply('{1'b0, 1'b0, 2'b00, 8'h01, 8'h01, 1'b0,
            8'hA4, 8'hA5, 8'hA5, 1'b0, 2'd1, 1'b1}, 101);
    apply('{1'b0, 1'b0, 2'b00, 8'h01, 8'h01, 1'b1,
            8'hA4, 8'hA5, 8'hA5, 1'b0, 2'd0, 1'b0}, 102);

    // Mode switch takes effect on the very edge it is sampled: SR into T.
    apply('{1'b0, 1'b1, 2'b11, 8'hFF, 8'h00, 1'b0,
            8'h5B, 8'h5A, 8'h5A, 1'b0, 2'd0, 1'b0}, 103);
    apply('{1'b0, 1'b1, 2'b00, 8'h80, 8'h01, 1'b0,
            8'hDA, 8'hDA, 8'hDA, 1'b0, 2'd0, 1'b0}, 104);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
